// File: rtl/register_file_if.sv
// Bus bundle for register_file: two read ports and one write port.
// The master drives addresses and write data; the slave returns A/B.
interface register_file_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [DATA_W-1:0] writedata;
  logic              regwrite;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;

  modport master (
    output rs, rt, rd, writedata, regwrite,
    input  A, B
  );

  modport slave (
    input  rs, rt, rd, writedata, regwrite,
    output A, B
  );
endinterface

// File: rtl/register_file.sv
// Two-read/one-write register file with a hardwired-zero register 0.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  localparam logic [5:0] NUM_REGS_L = 6'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              write_ok;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;

  // Register 0 and out-of-range addresses never accept a write.
  assign write_ok = bus.regwrite && (bus.rd != 5'd0) && ({1'b0, bus.rd} < NUM_REGS_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[bus.rd] <= bus.writedata;
    end
  end

  // Forwarding models the write-first-half, read-second-half timing of the datapath.
  always_comb begin
    a_val = '0;
    b_val = '0;
    if (!rst) begin
      if ((bus.rs != 5'd0) && ({1'b0, bus.rs} < NUM_REGS_L)) a_val = regs[bus.rs];
      if ((bus.rt != 5'd0) && ({1'b0, bus.rt} < NUM_REGS_L)) b_val = regs[bus.rt];
`ifdef REGISTER_FILE_BYPASS_EN
      if (write_ok && (bus.rs == bus.rd)) a_val = bus.writedata;
      if (write_ok && (bus.rt == bus.rd)) b_val = bus.writedata;
`endif
    end
  end

  assign bus.A = a_val;
  assign bus.B = b_val;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; expectations queue up as stimulus is driven
// and are checked against A/B shortly after each step settles.
module tb_register_file;

  localparam int DATA_W = 32;
`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  string             tagQ[$];
  logic [DATA_W-1:0] expAQ[$];
  logic [DATA_W-1:0] expBQ[$];

  register_file_if #(.DATA_W(DATA_W)) bus ();

  register_file #(.DATA_W(DATA_W), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic driveWrite(input logic [4:0] rdV, input logic [DATA_W-1:0] wdV);
    bus.rd        = rdV;
    bus.writedata = wdV;
    bus.regwrite  = 1'b1;
  endtask

  task automatic applyStimulus(input logic [4:0] rsV, input logic [4:0] rtV,
                               input logic [4:0] rdV, input logic [DATA_W-1:0] wdV,
                               input logic weV, input logic [DATA_W-1:0] expA,
                               input logic [DATA_W-1:0] expB, input string tag);
    bus.rs        = rsV;
    bus.rt        = rtV;
    bus.rd        = rdV;
    bus.writedata = wdV;
    bus.regwrite  = weV;
    tagQ.push_back(tag);
    expAQ.push_back(expA);
    expBQ.push_back(expB);
  endtask

  task automatic checkOutput();
    string             tag;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    #1;
    checks++;
    assert (tagQ.size() > 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end
    if (tagQ.size() > 0) begin
      tag = tagQ.pop_front();
      ea  = expAQ.pop_front();
      eb  = expBQ.pop_front();
      checks++;
      assert (bus.A === ea) else begin
        failures++;
        $error("[TB] FAIL %s.A: observed %0d expected %0d", tag, bus.A, ea);
      end
      checks++;
      assert (bus.B === eb) else begin
        failures++;
        $error("[TB] FAIL %s.B: observed %0d expected %0d", tag, bus.B, eb);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.writedata = '0; bus.regwrite = 1'b0;
    #1 rst = 1'b1;

    // Reset behaviour: reads during and after reset are zero.
    @(negedge clk);
    applyStimulus(5'd3, 5'd4, 5'd0, '0, 1'b0, 0, 0, "in_reset");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(5'd3, 5'd4, 5'd0, '0, 1'b0, 0, 0, "after_reset");
    checkOutput();

    // Write and read back.
    @(negedge clk); driveWrite(5'd4, 100);
    @(negedge clk); applyStimulus(5'd0, 5'd4, 5'd0, '0, 1'b0, 0, 100, "wr_r4");
    checkOutput();
    @(negedge clk); driveWrite(5'd3, 400);
    @(negedge clk); applyStimulus(5'd3, 5'd4, 5'd0, '0, 1'b0, 400, 100, "wr_r3");
    checkOutput();

    // Register 0 is protected.
    @(negedge clk); driveWrite(5'd0, 382);
    @(negedge clk); applyStimulus(5'd0, 5'd0, 5'd0, '0, 1'b0, 0, 0, "zero_reg");
    checkOutput();

    // Overwrite and untouched registers.
    @(negedge clk); driveWrite(5'd1, 600);
    @(negedge clk); driveWrite(5'd3, 50);
    @(negedge clk); applyStimulus(5'd1, 5'd3, 5'd0, '0, 1'b0, 600, 50, "overwrite");
    checkOutput();
    @(negedge clk); applyStimulus(5'd2, 5'd5, 5'd0, '0, 1'b0, 0, 0, "untouched");
    checkOutput();

    // Same-cycle read of the register being written.
    @(negedge clk);
    applyStimulus(5'd1, 5'd4, 5'd4, 77, 1'b1, 600, BYP ? 32'd77 : 32'd100, "same_cycle");
    checkOutput();
    @(negedge clk); applyStimulus(5'd1, 5'd4, 5'd0, '0, 1'b0, 600, 77, "after_edge");
    checkOutput();

    @(negedge clk);
    applyStimulus(5'd6, 5'd6, 5'd6, 55, 1'b1, BYP ? 32'd55 : 32'd0, BYP ? 32'd55 : 32'd0, "dual_fwd");
    checkOutput();
    @(negedge clk); applyStimulus(5'd6, 5'd6, 5'd0, '0, 1'b0, 55, 55, "dual_after");
    checkOutput();

    @(negedge clk); applyStimulus(5'd0, 5'd0, 5'd0, 382, 1'b1, 0, 0, "zero_fwd");
    checkOutput();

    // regwrite low must not disturb storage across an edge.
    @(negedge clk); applyStimulus(5'd7, 5'd4, 5'd7, 5, 1'b0, 0, 77, "no_write");
    checkOutput();
    @(negedge clk); applyStimulus(5'd7, 5'd4, 5'd7, 5, 1'b0, 0, 77, "no_write_hold");
    checkOutput();

    // Asynchronous reset mid-cycle with a pending write held across the edge.
    @(negedge clk);
    applyStimulus(5'd1, 5'd3, 5'd2, 999, 1'b1, 0, 0, "async_reset");
    #2 rst = 1'b1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(5'(2 * i), 5'(2 * i + 1), 5'd0, '0, 1'b0, 0, 0, $sformatf("cleared_%0d", i));
      checkOutput();
    end

    // First edge after reset accepts writes.
    @(negedge clk); driveWrite(5'd7, 123);
    @(negedge clk); applyStimulus(5'd7, 5'd2, 5'd0, '0, 1'b0, 123, 0, "post_reset_wr");
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data-port width in bits.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the register count; address width SHALL be 5 bits.
REQ-003 clk  input  1  SHALL be the single clock; all writes occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 rs  input  5  SHALL be the read address for port A.
REQ-006 rt  input  5  SHALL be the read address for port B.
REQ-007 rd  input  5  SHALL be the write address.
REQ-008 writedata  input  DATA_W  SHALL be the write data.
REQ-009 regwrite  input  1  SHALL be the write enable, active-high.
REQ-010 A  output  DATA_W  SHALL carry the contents of register rs.
REQ-011 B  output  DATA_W  SHALL carry the contents of register rt.

Function
REQ-012 Storage SHALL be NUM_REGS registers of DATA_W bits, indexed 0..31.
REQ-013 On a clk rising edge with rst low, regwrite=1 and rd!=0, the block SHALL load writedata into register rd.
REQ-014 Writes to register 0 SHALL be discarded.
REQ-015 A and B SHALL always read 0 when their address is 0.
REQ-016 The block SHALL perform no write when regwrite=0; all registers SHALL hold their values.
REQ-017 Reads SHALL be combinational, with zero-cycle latency from rs/rt to A/B.
REQ-018 A and B SHALL be independent; rs==rt SHALL give identical values on both ports.
REQ-019 Without the bypass feature, a write SHALL become visible on A/B immediately after the clk edge that performs it.
REQ-020 Only one write per cycle SHALL be possible; there is no write conflict.
REQ-021 A read of the register being written SHALL behave as defined in REQ-029 and REQ-030.

Reset
REQ-022 Asserting rst SHALL clear all registers to 0 immediately, independent of clk.
REQ-023 While rst is high, writes SHALL be blocked, and A and B SHALL read 0.
REQ-024 If rst is asserted mid-cycle during a pending write, the reset SHALL win: the register SHALL stay 0.
REQ-025 After rst deasserts, the first rising clk edge SHALL accept writes normally.

Configuration
REQ-026 Macro REGISTER_FILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-027 Forwarding SHALL follow the MIPS rule: write in the first half of the cycle, read in the second half.
REQ-028 Forwarding condition: regwrite=1, rd!=0, rst=0, and the read address equals rd.
REQ-029 With REGISTER_FILE_BYPASS_EN defined, when the forwarding condition holds, the matching port(s) SHALL output writedata combinationally in the same cycle.
REQ-030 With REGISTER_FILE_BYPASS_EN undefined, the port SHALL output the stored, pre-write value until the clk edge.

Verification
REQ-031 Reset behaviour: assert rst, then release it; read rs=3 and rt=4 -> A=0 and B=0.
REQ-032 Write and read back:
- regwrite=1, rd=4, writedata=100, one clk edge, then regwrite=0 and rt=4 -> B=100.
- Repeat with rd=3, writedata=400, then rs=3 -> A=400.
REQ-033 Zero-register protection: regwrite=1, rd=0, writedata=382, one clk edge, then rs=0 and rt=0 -> A=0 and B=0.
REQ-034 Overwrite:
- Write rd=1, writedata=600, then rd=3, writedata=50.
- Read rs=1 and rt=3 -> A=600 and B=50.
- Registers 2 and 5 -> 0.
REQ-035 Same-cycle read of the register being written: rd=rt=4, writedata=77, regwrite=1, before the clk edge.
- Bypass enabled -> B=77.
- Bypass disabled -> B equals the old value (100).
- After the clk edge -> B=77 in both builds.
REQ-036 Asynchronous reset: pulse rst between clk edges after the writes above -> A and B drop to 0 immediately, and all registers read 0 afterwards.
